// File: rtl/grf_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// grf_write_arbiter_if
// Purpose : Bundles the signals between the two writeback requesters, the GRF
//           write port, the hazard query and grf_write_arbiter.
// Params  : AW  - register address width
//           DW  - write-data width
//           PCW - PC tag width
// Signals : req0_* / req1_* - valid/addr/data/pc from the requester, ready back
//           grf_*           - registered GRF write port (we/a3/wd/pc)
//           qry_*           - in-flight write query (addr in, hit/data out)
// Modports: master - requester/GRF/hazard side
//           slave  - the arbiter
// -----------------------------------------------------------------------------
interface grf_write_arbiter_if #(
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter int PCW = 32
);
  logic           req0_valid;
  logic [AW-1:0]  req0_addr;
  logic [DW-1:0]  req0_data;
  logic [PCW-1:0] req0_pc;
  logic           req0_ready;

  logic           req1_valid;
  logic [AW-1:0]  req1_addr;
  logic [DW-1:0]  req1_data;
  logic [PCW-1:0] req1_pc;
  logic           req1_ready;

  logic           grf_we;
  logic [AW-1:0]  grf_a3;
  logic [DW-1:0]  grf_wd;
  logic [PCW-1:0] grf_pc;

  logic [AW-1:0]  qry_addr;
  logic           qry_hit;
  logic [DW-1:0]  qry_data;

  modport master (
    output req0_valid, req0_addr, req0_data, req0_pc,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data, req1_pc,
    input  req1_ready,
    input  grf_we, grf_a3, grf_wd, grf_pc,
    output qry_addr,
    input  qry_hit, qry_data
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_pc,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data, req1_pc,
    output req1_ready,
    output grf_we, grf_a3, grf_wd, grf_pc,
    input  qry_addr,
    output qry_hit, qry_data
  );
endinterface

// File: rtl/grf_write_arbiter.sv
// -----------------------------------------------------------------------------
// grf_write_arbiter
// Purpose : Shares the single GRF write port between port 0 (pipeline W stage)
//           and port 1 (multi-cycle unit / load return). Round-robin grant,
//           one registered output stage, plus an in-flight write query for
//           hazard logic.
// Ports   : clk   - system clock, rising edge
//           reset - synchronous, active-high reset
//           bus   - grf_write_arbiter_if.slave (requests, GRF port, query)
// Config  : GRF_ARB_FIXED_PRIO_EN - when defined, port 0 always wins a
//           contention and the round-robin pointer is not built.
// -----------------------------------------------------------------------------
module grf_write_arbiter #(
  parameter int AW  = 5,
  parameter int DW  = 32,
  parameter int PCW = 32
) (
  input  logic                clk,
  input  logic                reset,
  grf_write_arbiter_if.slave  bus
);

  logic           w_gnt0;
  logic           w_gnt1;
  logic [AW-1:0]  w_win_addr;
  logic [DW-1:0]  w_win_data;
  logic [PCW-1:0] w_win_pc;

  logic           r_we;
  logic [AW-1:0]  r_a3;
  logic [DW-1:0]  r_wd;
  logic [PCW-1:0] r_pc;

`ifdef GRF_ARB_FIXED_PRIO_EN
  // Port 0 drains every cycle in the target cores, so it simply wins.
  always_comb begin
    w_gnt0 = !reset && bus.req0_valid;
    w_gnt1 = !reset && bus.req1_valid && !bus.req0_valid;
  end
`else
  // r_rr_ptr names the port that wins the next contention.
  logic r_rr_ptr;

  always_comb begin
    w_gnt0 = !reset && bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
    w_gnt1 = !reset && bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
  end

  // The winner hands priority to the other port; idle cycles keep it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= 1'b0;
    end else if (w_gnt0) begin
      r_rr_ptr <= 1'b1;
    end else if (w_gnt1) begin
      r_rr_ptr <= 1'b0;
    end
  end
`endif

  // Grants are one-hot, so a two-way mux on w_gnt1 selects the winner.
  always_comb begin
    w_win_addr = w_gnt1 ? bus.req1_addr : bus.req0_addr;
    w_win_data = w_gnt1 ? bus.req1_data : bus.req0_data;
    w_win_pc   = w_gnt1 ? bus.req1_pc   : bus.req0_pc;
  end

  // Output stage: writes to $0 are consumed but never enable the GRF;
  // address/data/pc hold their values when nothing is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we <= 1'b0;
      r_a3 <= '0;
      r_wd <= '0;
      r_pc <= '0;
    end else if (w_gnt0 || w_gnt1) begin
      r_we <= (w_win_addr != '0);
      r_a3 <= w_win_addr;
      r_wd <= w_win_data;
      r_pc <= w_win_pc;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  assign bus.grf_we = r_we;
  assign bus.grf_a3 = r_a3;
  assign bus.grf_wd = r_wd;
  assign bus.grf_pc = r_pc;

  // $0 is hard-wired, so a pending "write" to it is never a hazard.
  assign bus.qry_hit  = r_we && (r_a3 == bus.qry_addr) && (bus.qry_addr != '0);
  assign bus.qry_data = r_wd;

endmodule

// File: tb/tb_grf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grf_write_arbiter
// Scoreboard bench: each stimulus cycle predicts the grant from the arbitration
// rules and pushes the expected GRF output for the following cycle; a monitor
// pops one entry per clock and compares the registered outputs and the query.
// -----------------------------------------------------------------------------
module tb_grf_write_arbiter;

  logic clk;
  logic reset;

  grf_write_arbiter_if #(.AW(5), .DW(32), .PCW(32)) bus ();

  grf_write_arbiter #(.AW(5), .DW(32), .PCW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          mon_en = 0;
  logic [4:0]  qa_cur = '0;

  // Reference state: what the GRF port currently shows, and which port was
  // served most recently (that port loses the next contention).
  logic [4:0]  m_a3 = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_pc = '0;
  int          m_last_served = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; returns the observed readies.
  task automatic step(input bit r,
                      input bit v0, input logic [4:0] a0, input logic [31:0] d0, input logic [31:0] p0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1, input logic [31:0] p1,
                      input logic [4:0] qa, output bit rd0, output bit rd1);
    int   g;
    exp_t e;
    @(negedge clk);
    mon_en         = 1;
    reset          = r;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0; bus.req0_pc = p0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1; bus.req1_pc = p1;
    bus.qry_addr   = qa;
    qa_cur         = qa;
    #1;
    if (r)             g = -1;
    else if (v0 && v1) begin
`ifdef GRF_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = (m_last_served == 0) ? 1 : 0;
`endif
    end
    else if (v0)       g = 0;
    else if (v1)       g = 1;
    else               g = -1;
    rd0 = bus.req0_ready;
    rd1 = bus.req1_ready;
    chk("ready0", {63'd0, rd0}, {63'd0, (g == 0)});
    chk("ready1", {63'd0, rd1}, {63'd0, (g == 1)});
    if (r) begin
      m_a3 = '0; m_wd = '0; m_pc = '0; m_last_served = 1;
      e.we = 1'b0;
    end else if (g >= 0) begin
      m_a3 = (g == 0) ? a0 : a1;
      m_wd = (g == 0) ? d0 : d1;
      m_pc = (g == 0) ? p0 : p1;
      m_last_served = g;
      e.we = (m_a3 != 0);
    end else begin
      e.we = 1'b0;
    end
    e.a3 = m_a3; e.wd = m_wd; e.pc = m_pc;
    q.push_back(e);
  endtask

  // Monitor: one expected entry per clock once stimulus has started.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("grf_we", {63'd0, bus.grf_we}, {63'd0, mon_e.we});
      chk("grf_a3", {59'd0, bus.grf_a3}, {59'd0, mon_e.a3});
      chk("grf_wd", {32'd0, bus.grf_wd}, {32'd0, mon_e.wd});
      chk("grf_pc", {32'd0, bus.grf_pc}, {32'd0, mon_e.pc});
      chk("qry_hit", {63'd0, bus.qry_hit},
          {63'd0, (mon_e.we && mon_e.a3 == qa_cur && qa_cur != 0)});
      if (mon_e.we && mon_e.a3 == qa_cur && qa_cur != 0)
        chk("qry_data", {32'd0, bus.qry_data}, {32'd0, mon_e.wd});
      $display("cycle t=%0t we=%0b a3=%0d wd=%08h pc=%08h qa=%0d hit=%0b",
               $time, bus.grf_we, bus.grf_a3, bus.grf_wd, bus.grf_pc, qa_cur, bus.qry_hit);
    end else if (mon_en) begin
      chk("scoreboard_underflow", 64'd1, 64'd0);
    end
  end

  bit          rd0, rd1;
  bit          p0v, p1v, w0, w1;
  logic [4:0]  p0a, p1a;
  logic [31:0] p0d, p1d, p0p, p1p;

  initial begin
    reset = 1'b1;
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0; bus.req0_pc = '0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0; bus.req1_pc = '0;
    bus.qry_addr = '0;

    // 1: reset with a pending request -> not accepted, outputs cleared.
    step(1, 1, 5'd3, 32'h55, 32'h10, 0, 0, 0, 0, 0, rd0, rd1);
    chk("t1_ready0_in_reset", {63'd0, rd0}, 64'd0);

    // 2: lone port 0 request.
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 32'h3000, 0, 0, 0, 0, 5'd5, rd0, rd1);
    chk("t2_ready0", {63'd0, rd0}, 64'd1);

    // 3: both valid for 4 cycles straight after reset.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd0, rd1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 5'd1, 32'h100 + k, 32'h4000 + 4*k, 1, 5'd2, 32'h200 + k, 32'h5000 + 4*k, 5'd1, rd0, rd1);
`ifdef GRF_ARB_FIXED_PRIO_EN
      chk("t3_grant_port", {63'd0, rd1}, 64'd0);
`else
      chk("t3_grant_port", {63'd0, rd1}, 64'(k % 2));
`endif
    end

    // 4: write to $0 from port 1 is consumed but not enabled.
    step(0, 0, 0, 0, 0, 1, 5'd0, 32'h1234, 32'h6000, 5'd0, rd0, rd1);
    chk("t4_ready1", {63'd0, rd1}, 64'd1);

    // 5: in-flight query hit on 7, miss on 8.
    step(0, 1, 5'd7, 32'hCAFE_0007, 32'h7000, 0, 0, 0, 0, 5'd7, rd0, rd1);
    step(0, 1, 5'd7, 32'hCAFE_0008, 32'h7004, 0, 0, 0, 0, 5'd8, rd0, rd1);

    // 6: same address on both ports, then reset mid-stream.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rd0, rd1);
    step(0, 1, 5'd9, 32'hA, 32'h8000, 1, 5'd9, 32'hB, 32'h8004, 5'd9, rd0, rd1);
    step(0, 0, 0, 0, 0, 1, 5'd9, 32'hB, 32'h8004, 5'd9, rd0, rd1);
`ifndef GRF_ARB_FIXED_PRIO_EN
    chk("t6_loser_follows", {63'd0, rd1}, 64'd1);
`endif
    step(0, 1, 5'd9, 32'hA, 32'h8000, 1, 5'd9, 32'hB, 32'h8004, 5'd9, rd0, rd1);
    step(1, 0, 0, 0, 0, 1, 5'd9, 32'hB, 32'h8004, 5'd9, rd0, rd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, rd0, rd1);

    // Random traffic: requesters hold until ready, sometimes withdraw.
    p0v = 0; p1v = 0;
    p0a = '0; p1a = '0; p0d = '0; p1d = '0; p0p = '0; p1p = '0;
    for (int n = 0; n < 400; n++) begin
      bit r;
      r = ($urandom_range(0, 49) == 0);
      if (!p0v && $urandom_range(0, 2) != 0) begin
        p0v = 1; p0a = 5'($urandom_range(0, 7)); p0d = $urandom; p0p = $urandom;
      end
      if (!p1v && $urandom_range(0, 2) != 0) begin
        p1v = 1; p1a = 5'($urandom_range(0, 7)); p1d = $urandom; p1p = $urandom;
      end
      w0 = p0v; w1 = p1v;
      if (p0v && $urandom_range(0, 15) == 0) begin w0 = 0; p0v = 0; end
      if (p1v && $urandom_range(0, 15) == 0) begin w1 = 0; p1v = 0; end
      step(r, w0, p0a, p0d, p0p, w1, p1a, p1d, p1p, 5'($urandom_range(0, 7)), rd0, rd1);
      if (rd0) p0v = 0;
      if (rd1) p1v = 0;
    end

    @(posedge clk);
    #3;
    mon_en = 0;
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
